operand_fetch: RTL

//  Decode-to-issue stage of the RV64 pipeline. Takes one decoded instruction at a time from the decoder.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/operand_bypass.sv | 73 +++++++
 rtl/operand_fetch.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline types for the RV64 core: widths, register index, forwarding selector, issue record.
// Pure declarations: no latency, no handshake.
package cpu_pkg;
  localparam int XLEN  = 64;
  localparam int UOP_W = 16;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_WB,
    FWD_MEM,
    FWD_EX
  } fwd_sel_e;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [UOP_W-1:0] uop;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;
    reg_idx_t         rd_addr;
    logic             rd_wr;
  } iss_t;
endpackage

// File: rtl/operand_bypass.sv
// One-operand hazard detect and forwarding mux (EX > MEM > WB > regfile); combinational, 0 cycles.
// Raises stall_req_o when the operand is needed but cannot be forwarded (EX/MEM paths gated by OPFETCH_BYPASS_EN).
module operand_bypass
  import cpu_pkg::*;
(
  input  logic            use_i,
  input  logic [4:0]      addr_i,
  input  logic [XLEN-1:0] rf_data_i,
  input  logic            ex_valid_i,
  input  logic            ex_rd_wr_i,
  input  logic            ex_is_load_i,
  input  logic [4:0]      ex_rd_addr_i,
  input  logic [XLEN-1:0] ex_result_i,
  input  logic            mem_valid_i,
  input  logic            mem_rd_wr_i,
  input  logic            mem_is_load_i,
  input  logic            mem_data_valid_i,
  input  logic [4:0]      mem_rd_addr_i,
  input  logic [XLEN-1:0] mem_result_i,
  input  logic            wb_wr_en_i,
  input  logic [4:0]      wb_rd_addr_i,
  input  logic [XLEN-1:0] wb_wr_data_i,
  output logic [XLEN-1:0] value_o,
  output logic            stall_req_o
);
  logic     needs_src;
  logic     ex_match;
  logic     mem_match;
  logic     wb_match;
  fwd_sel_e sel;

  // x0 is hardwired zero, so it never matches a producer
  assign needs_src = use_i && (addr_i != 5'd0);
  assign ex_match  = needs_src && ex_valid_i && ex_rd_wr_i && (ex_rd_addr_i == addr_i);
  assign mem_match = needs_src && mem_valid_i && mem_rd_wr_i && (mem_rd_addr_i == addr_i);
  assign wb_match  = needs_src && wb_wr_en_i && (wb_rd_addr_i == addr_i);

`ifdef OPFETCH_BYPASS_EN
  always_comb begin
    sel         = FWD_RF;
    stall_req_o = 1'b0;
    if (ex_match) begin
      if (ex_is_load_i) stall_req_o = 1'b1;
      else              sel         = FWD_EX;
    end else if (mem_match) begin
      if (mem_is_load_i && !mem_data_valid_i) stall_req_o = 1'b1;
      else                                    sel         = FWD_MEM;
    end else if (wb_match) begin
      sel = FWD_WB;
    end
  end
`else
  logic unused_load_info;
  assign unused_load_info = ^{ex_is_load_i, mem_is_load_i, mem_data_valid_i};

  always_comb begin
    sel         = FWD_RF;
    stall_req_o = 1'b0;
    if (ex_match || mem_match) stall_req_o = 1'b1;
    else if (wb_match)         sel         = FWD_WB;
  end
`endif

  // WB must be bypassed: the regfile write only lands at the next edge
  always_comb begin
    case (sel)
      FWD_EX:  value_o = ex_result_i;
      FWD_MEM: value_o = mem_result_i;
      FWD_WB:  value_o = wb_wr_data_i;
      default: value_o = (addr_i == 5'd0) ? '0 : rf_data_i;
    endcase
  end
endmodule

// File: rtl/operand_fetch.sv
// Decode-to-issue stage: regfile read + RAW resolution into a 1-entry issue register, 1-cycle latency.
// Valid/ready to execute; decoder stalled on unforwardable hazard, full issue reg, or flush (OPFETCH_BYPASS_EN adds EX/MEM forwarding).
module operand_fetch
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             dec_valid_i,
  output logic             dec_ready_o,
  input  logic [XLEN-1:0]  dec_pc_i,
  input  logic [UOP_W-1:0] dec_uop_i,
  input  logic [XLEN-1:0]  dec_imm_i,
  input  logic [4:0]       dec_rs1_addr_i,
  input  logic [4:0]       dec_rs2_addr_i,
  input  logic             dec_rs1_use_i,
  input  logic             dec_rs2_use_i,
  input  logic [4:0]       dec_rd_addr_i,
  input  logic             dec_rd_wr_i,
  output logic [4:0]       rf_rs1_addr_o,
  output logic [4:0]       rf_rs2_addr_o,
  input  logic [XLEN-1:0]  rf_rs1_data_i,
  input  logic [XLEN-1:0]  rf_rs2_data_i,
  input  logic             ex_valid_i,
  input  logic             ex_rd_wr_i,
  input  logic             ex_is_load_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic [XLEN-1:0]  ex_result_i,
  input  logic             mem_valid_i,
  input  logic             mem_rd_wr_i,
  input  logic             mem_is_load_i,
  input  logic             mem_data_valid_i,
  input  logic [4:0]       mem_rd_addr_i,
  input  logic [XLEN-1:0]  mem_result_i,
  input  logic             wb_wr_en_i,
  input  logic [4:0]       wb_rd_addr_i,
  input  logic [XLEN-1:0]  wb_wr_data_i,
  output logic             iss_valid_o,
  input  logic             iss_ready_i,
  output logic [XLEN-1:0]  iss_pc_o,
  output logic [XLEN-1:0]  iss_imm_o,
  output logic [XLEN-1:0]  iss_rs1_val_o,
  output logic [XLEN-1:0]  iss_rs2_val_o,
  output logic [UOP_W-1:0] iss_uop_o,
  output logic [4:0]       iss_rd_addr_o,
  output logic             iss_rd_wr_o
);
  logic            iss_valid_q, iss_valid_d;
  iss_t            iss_q, iss_d;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            rs1_stall, rs2_stall;
  logic            accept;

  assign rf_rs1_addr_o = dec_rs1_addr_i;
  assign rf_rs2_addr_o = dec_rs2_addr_i;

  operand_bypass u_rs1 (
    .use_i(dec_rs1_use_i), .addr_i(dec_rs1_addr_i), .rf_data_i(rf_rs1_data_i),
    .ex_valid_i(ex_valid_i), .ex_rd_wr_i(ex_rd_wr_i), .ex_is_load_i(ex_is_load_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_result_i(ex_result_i),
    .mem_valid_i(mem_valid_i), .mem_rd_wr_i(mem_rd_wr_i), .mem_is_load_i(mem_is_load_i),
    .mem_data_valid_i(mem_data_valid_i), .mem_rd_addr_i(mem_rd_addr_i), .mem_result_i(mem_result_i),
    .wb_wr_en_i(wb_wr_en_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_wr_data_i(wb_wr_data_i),
    .value_o(rs1_val), .stall_req_o(rs1_stall)
  );

  operand_bypass u_rs2 (
    .use_i(dec_rs2_use_i), .addr_i(dec_rs2_addr_i), .rf_data_i(rf_rs2_data_i),
    .ex_valid_i(ex_valid_i), .ex_rd_wr_i(ex_rd_wr_i), .ex_is_load_i(ex_is_load_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_result_i(ex_result_i),
    .mem_valid_i(mem_valid_i), .mem_rd_wr_i(mem_rd_wr_i), .mem_is_load_i(mem_is_load_i),
    .mem_data_valid_i(mem_data_valid_i), .mem_rd_addr_i(mem_rd_addr_i), .mem_result_i(mem_result_i),
    .wb_wr_en_i(wb_wr_en_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_wr_data_i(wb_wr_data_i),
    .value_o(rs2_val), .stall_req_o(rs2_stall)
  );

  assign dec_ready_o = !(rs1_stall || rs2_stall) && (!iss_valid_q || iss_ready_i) && !flush_i;
  assign accept      = dec_valid_i && dec_ready_o;

  // Flush wins over both accept and consume; data fields only change on accept
  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_d       = iss_q;
    if (flush_i) begin
      iss_valid_d = 1'b0;
    end else if (accept) begin
      iss_valid_d   = 1'b1;
      iss_d.pc      = dec_pc_i;
      iss_d.uop     = dec_uop_i;
      iss_d.imm     = dec_imm_i;
      iss_d.rs1_val = rs1_val;
      iss_d.rs2_val = rs2_val;
      iss_d.rd_addr = dec_rd_addr_i;
      iss_d.rd_wr   = dec_rd_wr_i;
    end else if (iss_valid_q && iss_ready_i) begin
      iss_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss_valid_q <= 1'b0;
      iss_q       <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_q       <= iss_d;
    end
  end

  assign iss_valid_o   = iss_valid_q;
  assign iss_pc_o      = iss_q.pc;
  assign iss_uop_o     = iss_q.uop;
  assign iss_imm_o     = iss_q.imm;
  assign iss_rs1_val_o = iss_q.rs1_val;
  assign iss_rs2_val_o = iss_q.rs2_val;
  assign iss_rd_addr_o = iss_q.rd_addr;
  assign iss_rd_wr_o   = iss_q.rd_wr;
endmodule
